fixed_128_sub_seq: RTL and testbench

- Sequential 128-bit signed fixed-point subtractor (Q120.8): diff = a_in - b_in.
- Result carries overflow/underflow flags.
- Computes serially in CHUNK_W-bit slices, propagating a borrow between slices, so the datapath meets timing at high clock rates.
- Sits beside the combinational adder in the gradient/value-difference path. It supplies the error term (prediction - target) to the regressor update, using valid/ready handshakes on both sides.

---
 rtl/fixed_128_sub_seq.sv | 132 +++++++++++++
 tb/tb_fixed_128_sub_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_128_sub_seq.sv
// Sequential 128-bit signed Q120.8 subtractor: CHUNK_W-bit slice per cycle with a registered borrow.
// Optional build macro FIXED_SUB_SATURATE_EN clamps diff to max/min on overflow/underflow.
module fixed_128_sub_seq #(
  parameter int unsigned CHUNK_W   = 32,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] a_in,
  input  logic [127:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] diff,
  output logic         overflow,
  output logic         underflow_q,
  output logic         busy
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SLC_W  = CHUNK_W + 1;

  // Reject slice widths that do not tile the word and formats with no integer part.
  if ((DATA_W % CHUNK_W) != 0 || FRAC_BITS >= DATA_W) begin : g_cfg_check
    $error("fixed_128_sub_seq: CHUNK_W must divide 128 and FRAC_BITS must be < 128");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  a_q, a_nxt;
  logic [DATA_W-1:0]  b_q, b_nxt;
  logic [DATA_W-1:0]  diff_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               borrow, borrow_nxt;
  logic               ovf_nxt, unf_nxt;
  logic               in_ready_nxt, out_valid_nxt, busy_nxt;
  logic [SLC_W-1:0]   slice;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      borrow      <= 1'b0;
      diff        <= '0;
      overflow    <= 1'b0;
      underflow_q <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      idx         <= idx_nxt;
      borrow      <= borrow_nxt;
      diff        <= diff_nxt;
      overflow    <= ovf_nxt;
      underflow_q <= unf_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = a_q;
    b_nxt      = b_q;
    idx_nxt    = idx;
    borrow_nxt = borrow;
    diff_nxt   = diff;
    ovf_nxt    = overflow;
    unf_nxt    = underflow_q;
    slice      = '0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt      = a_in;
          b_nxt      = b_in;
          idx_nxt    = '0;
          borrow_nxt = 1'b0;
          ovf_nxt    = 1'b0;
          unf_nxt    = 1'b0;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        // Zero-extended slice subtract; the extra MSB is the borrow out.
        slice = {1'b0, a_q[idx*CHUNK_W +: CHUNK_W]}
              - {1'b0, b_q[idx*CHUNK_W +: CHUNK_W]}
              - SLC_W'(borrow);
        diff_nxt[idx*CHUNK_W +: CHUNK_W] = slice[CHUNK_W-1:0];
        borrow_nxt = slice[CHUNK_W];
        idx_nxt    = IDX_W'(idx + 1'b1);
        if (idx == IDX_W'(NCHUNK - 1)) begin
          state_nxt = DONE;
          ovf_nxt   = !a_q[DATA_W-1] &&  b_q[DATA_W-1] &&  diff_nxt[DATA_W-1];
          unf_nxt   =  a_q[DATA_W-1] && !b_q[DATA_W-1] && !diff_nxt[DATA_W-1];
`ifdef FIXED_SUB_SATURATE_EN
          if (ovf_nxt) begin
            diff_nxt = {1'b0, {(DATA_W-1){1'b1}}};
          end else if (unf_nxt) begin
            diff_nxt = {1'b1, {(DATA_W-1){1'b0}}};
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_fixed_128_sub_seq.sv
// Self-checking bench for fixed_128_sub_seq: directed corner cases plus random operands
// checked against a wide-arithmetic range model; honours FIXED_SUB_SATURATE_EN.
module tb_fixed_128_sub_seq;

  localparam int unsigned CHUNK_W = 32;
  localparam int unsigned NCHUNK  = 128 / CHUNK_W;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a_in;
  logic [127:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] diff;
  logic         overflow;
  logic         underflow_q;
  logic         busy;

  int total;
  int bad;

  fixed_128_sub_seq #(.CHUNK_W(CHUNK_W), .FRAC_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .overflow   (overflow),
    .underflow_q(underflow_q),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True signed difference in 129 bits; out-of-range results raise a flag.
  function automatic void model(input logic [127:0] a, input logic [127:0] b,
                                output logic [127:0] d, output logic o, output logic u);
    logic [128:0] t;
    t = {a[127], a} - {b[127], b};
    o = (t[128] == 1'b0) && (t[127] == 1'b1);
    u = (t[128] == 1'b1) && (t[127] == 1'b0);
    d = t[127:0];
`ifdef FIXED_SUB_SATURATE_EN
    if (o) d = {1'b0, {127{1'b1}}};
    if (u) d = {1'b1, {127{1'b0}}};
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input string name, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ed;
    logic eo, eu;
    int lat;
    model(a, b, ed, eo, eu);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s ready: in_ready=%b expected 1", name, in_ready);
    end
    in_valid = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 1'b0; a_in = rand128(); b_in = rand128();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s calc: busy=%b in_ready=%b expected 1/0", name, busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    total++;
    if (lat != NCHUNK) begin
      bad++; $display("FAIL %s latency: got %0d expected %0d", name, lat, NCHUNK);
    end
    total++;
    if (diff !== ed || overflow !== eo || underflow_q !== eu) begin
      bad++;
      $display("FAIL %s result: diff=%h ovf=%b unf=%b expected diff=%h ovf=%b unf=%b",
               name, diff, overflow, underflow_q, ed, eo, eu);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                      name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        diff !== 128'd0 || overflow !== 1'b0 || underflow_q !== 1'b0) begin
      bad++; $display("FAIL reset: in_ready=%b out_valid=%b busy=%b diff=%h ovf=%b unf=%b expected 1/0/0/0/0/0",
                      in_ready, out_valid, busy, diff, overflow, underflow_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [127:0] maxp, minn, ones;
    maxp = {1'b0, {127{1'b1}}};
    minn = {1'b1, {127{1'b0}}};
    ones = {128{1'b1}};
    run_op("basic", 128'h500, 128'h300);
    run_op("borrow", 128'h1_0000_0000, 128'h1);
    run_op("overflow", maxp, ones);
    run_op("underflow", minn, 128'h1);
    run_op("zero_minus_min", 128'h0, minn);
    run_op("min_minus_min", minn, minn);
  endtask

  task automatic test_random();
    logic [127:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = rand128();
      b = rand128();
      // Bias half the cases toward opposite signs near the range limits.
      if (i % 2 == 1) begin
        a[127:124] = (i % 4 == 1) ? 4'b0111 : 4'b1000;
        b[127:124] = (i % 4 == 1) ? 4'b1000 : 4'b0111;
      end
      run_op("random", a, b);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a1, b1, a2, b2, ed1, ed2;
    logic eo1, eu1, eo2, eu2;
    int lat;
    a1 = rand128(); b1 = rand128(); a2 = rand128(); b2 = rand128();
    model(a1, b1, ed1, eo1, eu1);
    model(a2, b2, ed2, eo2, eu2);
    @(negedge clk);
    in_valid = 1'b1; a_in = a1; b_in = b1;
    @(negedge clk);
    a_in = a2; b_in = b2;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    total++;
    if (lat != NCHUNK) begin
      bad++; $display("FAIL bp latency: got %0d expected %0d", lat, NCHUNK);
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed1 ||
          overflow !== eo1 || underflow_q !== eu1) begin
        bad++; $display("FAIL bp hold: out_valid=%b in_ready=%b diff=%h ovf=%b unf=%b expected 1/0 diff=%h ovf=%b unf=%b",
                        out_valid, in_ready, diff, overflow, underflow_q, ed1, eo1, eu1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp second accept: busy=%b in_ready=%b expected 1/0", busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    total++;
    if (lat != NCHUNK || diff !== ed2 || overflow !== eo2 || underflow_q !== eu2) begin
      bad++; $display("FAIL bp second: lat=%0d diff=%h ovf=%b unf=%b expected lat=%0d diff=%h ovf=%b unf=%b",
                      lat, diff, overflow, underflow_q, NCHUNK, ed2, eo2, eu2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first, second, spin;
    first = -1; second = -1;
    in_valid = 1'b1; a_in = rand128(); b_in = rand128(); out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    in_valid = 1'b0;
    total++;
    if (first < 0 || second - first != NCHUNK + 2) begin
      bad++; $display("FAIL throughput: accept spacing=%0d expected %0d", second - first, NCHUNK + 2);
    end
    spin = 0;
    while ((in_ready !== 1'b1 || out_valid !== 1'b0) && spin < 20) begin
      @(negedge clk); spin++;
    end
    out_ready = 1'b0;
    total++;
    if (spin >= 20) begin
      bad++; $display("FAIL drain: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; a_in = rand128(); b_in = rand128(); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        diff !== 128'd0 || overflow !== 1'b0 || underflow_q !== 1'b0) begin
      bad++; $display("FAIL mid reset: in_ready=%b out_valid=%b busy=%b diff=%h ovf=%b unf=%b expected 1/0/0/0/0/0",
                      in_ready, out_valid, busy, diff, overflow, underflow_q);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (seen) begin
      bad++; $display("FAIL aborted op: out_valid/busy rose=%b expected 0", seen);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    run_op("after_reset", 128'h500, 128'h300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
